// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a five-stage pipeline. It resolves load-use, taken-branch,
// cache-wait and halt-drain events into hold/flush controls, and counts PC stall cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_rt_dest,
  input  logic        ex_branch_taken,
  input  logic        ex_halt,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // Return state recorded when a cache wait begins.
  typedef enum logic {
    RET_RUN   = 1'b0,
    RET_DRAIN = 1'b1
  } ret_e;

  state_e      state_q, state_d;
  ret_e        ret_q, ret_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic load_use;
  logic eval_run;
  logic eval_drain;

  assign load_use = ex_mem_to_reg && (ex_rt_dest != 5'd0) &&
                    ((ex_rt_dest == id_rs) || (id_uses_rt && (ex_rt_dest == id_rt)));

  // A cache wait in progress only ends on mem_ready; elsewhere a new request must be pending.
  assign mem_stall = (state_q == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  // When a cache wait releases, the lower-priority sources are judged as in the return state.
  assign eval_run   = (state_q == ST_RUN) ||
                      ((state_q == ST_MEM_WAIT) && (ret_q == RET_RUN));
  assign eval_drain = (state_q == ST_DRAIN) ||
                      ((state_q == ST_MEM_WAIT) && (ret_q == RET_DRAIN));

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    if (rst) begin
      // Outputs stay quiet while reset is held; the register block does the state reset.
    end else if (state_q == ST_HALTED) begin
      halted     = 1'b1;
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      id_ex_hold = 1'b1;
    end else if (mem_stall) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      id_ex_hold = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        ret_d   = (state_q == ST_DRAIN) ? RET_DRAIN : RET_RUN;
        state_d = ST_MEM_WAIT;
      end
    end else begin
      state_d = eval_drain ? ST_DRAIN : ST_RUN;
      if (eval_run) begin
        if (ex_halt) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_DRAIN;
          cnt_d       = 4'(DRAIN_CYCLES - 1);
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
      end else begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (state_q != ST_HALTED) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_q       <= RET_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch, cache wait, halt drain,
// reset aborts and stall counter saturation, against hand-computed control vectors.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt_dest;
  logic        id_uses_rt, ex_mem_to_reg, ex_branch_taken, ex_halt;
  logic        mem_req, mem_ready;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halted;
  logic [31:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Control vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halted}
  localparam logic [5:0] C_IDLE   = 6'b000000;
  localparam logic [5:0] C_LDUSE  = 6'b110010;
  localparam logic [5:0] C_BRANCH = 6'b001010;
  localparam logic [5:0] C_MEM    = 6'b110100;
  localparam logic [5:0] C_BUBBLE = 6'b101010;
  localparam logic [5:0] C_HALTED = 6'b110101;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_rt_dest     (ex_rt_dest),
    .ex_branch_taken(ex_branch_taken),
    .ex_halt        (ex_halt),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_hold     (id_ex_hold),
    .id_ex_flush    (id_ex_flush),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halted};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_to_reg = 1'b0; ex_rt_dest = 5'd0;
    ex_branch_taken = 1'b0; ex_halt = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the current inputs, let them settle, compare the control vector, then clock.
  task automatic step(input string tag, input logic [5:0] exp);
    #1;
    check(tag, 32'(ctl()), 32'(exp));
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    // Held reset: outputs are forced quiet even with active hazard sources.
    ex_halt = 1'b1; mem_req = 1'b1; ex_branch_taken = 1'b1;
    #1;
    check("rst_ctl", 32'(ctl()), 32'(C_IDLE));
    check("rst_stall", stall_cycles, 32'd0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    check("post_rst_ctl", 32'(ctl()), 32'(C_IDLE));

    // Load-use on rs.
    ex_mem_to_reg = 1'b1; ex_rt_dest = 5'd5; id_rs = 5'd5;
    step("lduse_rs", C_LDUSE);
    idle();
    #1;
    check("lduse_gone", 32'(ctl()), 32'(C_IDLE));
    check("lduse_stall", stall_cycles, 32'd1);
    // Destination r0 never creates a hazard.
    ex_mem_to_reg = 1'b1; ex_rt_dest = 5'd0; id_rs = 5'd0;
    step("lduse_r0", C_IDLE);
    // rt match counts only when rt is a source.
    ex_mem_to_reg = 1'b1; ex_rt_dest = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
    step("lduse_rt", C_LDUSE);
    id_uses_rt = 1'b0;
    step("lduse_rt_unused", C_IDLE);
    idle();
    check("lduse_stall2", stall_cycles, 32'd2);

    // Taken branch, alone and together with a load-use hazard.
    ex_branch_taken = 1'b1;
    step("branch", C_BRANCH);
    ex_mem_to_reg = 1'b1; ex_rt_dest = 5'd9; id_rs = 5'd9;
    step("branch_lduse", C_BRANCH);
    idle();
    check("branch_stall", stall_cycles, 32'd2);

    // Cache wait: 4 hold cycles, released in the mem_ready cycle.
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("mem_hold%0d", i), C_MEM);
    mem_ready = 1'b1;
    step("mem_ready", C_IDLE);
    idle();
    check("mem_stall_cnt", stall_cycles, 32'd6);

    // Cache wait with a pending branch: flush only in the mem_ready cycle.
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("mem_br_hold%0d", i), C_MEM);
    mem_ready = 1'b1;
    step("mem_br_ready", C_BRANCH);
    idle();
    check("mem_br_stall", stall_cycles, 32'd10);

    // Halt: 4 bubble cycles, then halted with all holds.
    ex_halt = 1'b1;
    step("halt0", C_BUBBLE);
    idle();
    for (int i = 1; i < 4; i++) step($sformatf("drain%0d", i), C_BUBBLE);
    ex_branch_taken = 1'b1;
    step("halted", C_HALTED);
    step("halted_stays", C_HALTED);
    check("halted_stall", stall_cycles, 32'd14);
    idle();

    // Halt with a 2-cycle cache stall inside the drain.
    do_reset();
    #1;
    check("rst2_stall", stall_cycles, 32'd0);
    ex_halt = 1'b1;
    step("hm_halt", C_BUBBLE);
    idle();
    step("hm_drain1", C_BUBBLE);
    mem_req = 1'b1;
    step("hm_mem0", C_MEM);
    step("hm_mem1", C_MEM);
    mem_req = 1'b0; mem_ready = 1'b1;
    step("hm_drain2", C_BUBBLE);
    idle();
    step("hm_drain3", C_BUBBLE);
    step("hm_halted", C_HALTED);
    check("hm_stall", stall_cycles, 32'd6);

    // Reset mid-drain aborts to RUN.
    do_reset();
    ex_halt = 1'b1;
    step("rd_halt", C_BUBBLE);
    idle();
    step("rd_drain1", C_BUBBLE);
    rst = 1'b1;
    step("rd_rst", C_IDLE);
    rst = 1'b0;
    #1;
    check("rd_after_ctl", 32'(ctl()), 32'(C_IDLE));
    check("rd_after_stall", stall_cycles, 32'd0);
    ex_branch_taken = 1'b1;
    step("rd_run_branch", C_BRANCH);
    idle();

    // Reset mid-MEM_WAIT aborts to RUN.
    mem_req = 1'b1;
    step("rm_mem0", C_MEM);
    step("rm_mem1", C_MEM);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step("rm_after", C_IDLE);

    // Saturation of the stall counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("sat_hold%0d", i), C_MEM);
    check("sat_max", stall_cycles, 32'hFFFF_FFFF);
    mem_ready = 1'b1;
    step("sat_ready", C_IDLE);
    idle();
    ex_mem_to_reg = 1'b1; ex_rt_dest = 5'd4; id_rs = 5'd4;
    step("sat_lduse", C_LDUSE);
    idle();
    check("sat_stays", stall_cycles, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It watches the ID, EX and MEM stages and drives the hold and flush controls of the PC, IF/ID and ID/EX pipeline registers. It handles four cases: load-use hazards, taken-branch squashes, multi-cycle cache accesses and the end-of-program halt drain. The ID/EX register freezes on `id_ex_hold`, in the same way it freezes on a pending cache access.

## Interface
- `DRAIN_CYCLES`, default 3: bubble cycles injected after a halt reaches EX, before `halted` asserts. Legal range 1–15.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt as a source.
- `ex_mem_to_reg` in 1: the instruction in EX is a load.
- `ex_rt_dest` in 5: rt field (load destination) of the instruction in EX.
- `ex_branch_taken` in 1: the branch in EX resolved taken.
- `ex_halt` in 1: a halt instruction is in EX.
- `mem_req` in 1: the instruction in MEM accesses the cache.
- `mem_ready` in 1: the cache access completes this cycle.
- `pc_hold` out 1: PC keeps its value.
- `if_id_hold` out 1: IF/ID keeps its contents.
- `if_id_flush` out 1: IF/ID loads a bubble. Hold takes precedence at the register.
- `id_ex_hold` out 1: ID/EX keeps its contents.
- `id_ex_flush` out 1: ID/EX loads a bubble.
- `halted` out 1: the pipeline is drained and stopped.
- `stall_cycles` out 32: performance counter of cycles with `pc_hold` asserted.

## Operation
- The FSM has four states: RUN, MEM_WAIT, DRAIN, HALTED. Reset enters RUN.
- Control outputs are combinational from the state and the current inputs (Mealy), so a stall takes effect in the same cycle as its cause.
- `mem_stall` is defined as `mem_req & !mem_ready` in RUN or DRAIN, and as `!mem_ready` in MEM_WAIT.
- In every state except HALTED, sources are evaluated in this priority order:
  1. **mem_stall:** all three holds assert and both flushes are 0. RUN and DRAIN move to MEM_WAIT. The drain counter does not change.
  2. **ex_halt, in RUN only:** `pc_hold`, `if_id_flush` and `id_ex_flush` assert. The state moves to DRAIN and `cnt` loads DRAIN_CYCLES-1.
  3. **ex_branch_taken, in RUN only:** `if_id_flush` and `id_ex_flush` assert for that cycle. The PC is not held.
  4. **Load-use hazard, in RUN only:** the hazard exists when `ex_mem_to_reg` is 1, `ex_rt_dest` is nonzero, and `ex_rt_dest` equals `id_rs`, or equals `id_rt` with `id_uses_rt` set. Response: `pc_hold`, `if_id_hold` and `id_ex_flush` assert. This lasts one cycle because the bubble then clears the condition.
- **MEM_WAIT:** holds stay asserted until `mem_ready`. On `mem_ready` the holds drop in that same cycle and the lower-priority sources are evaluated as above. The next state is the state recorded on entry (RUN or DRAIN), held in a 1-bit `ret` register.
- **DRAIN:** each cycle without mem_stall asserts `pc_hold`, `if_id_flush` and `id_ex_flush`.
  - If `cnt` is 0, the next state is HALTED.
  - Otherwise `cnt` decrements.
  - Branch and load-use inputs are ignored in DRAIN.
- **HALTED:** `halted`, `pc_hold`, `if_id_hold` and `id_ex_hold` are 1, and both flushes are 0. The state is left only by `rst`.
- **stall_cycles:** increments by 1 on each edge where `pc_hold` is 1 and the state is not HALTED. It saturates at 0xFFFFFFFF.

## Timing
- Reset values, for the cycle after `rst` and for the whole time `rst` is held:
  - State RUN, `cnt` = 0, `ret` = RUN, `stall_cycles` = 0.
  - `halted` = 0 and the `ret` register = RUN.
  - Outputs in the reset cycle are forced to: all holds 0, all flushes 0.
- Asserting `rst` mid-drain or mid-MEM_WAIT aborts immediately to RUN.
- Latency of response to every hazard source is 0 cycles.
- A load-use hazard costs 1 bubble. A taken branch costs 2 squashed slots.
- A cache access with `mem_ready` arriving N cycles after `mem_req` causes N hold cycles.
- Halt to `halted` takes DRAIN_CYCLES+1 cycles plus any memory-stall cycles that occur during the drain.
- Simultaneous events:
  - mem_stall together with a branch: the branch stays pending, because EX is frozen, and its flush applies in the `mem_ready` cycle.
  - Branch together with load-use: only the flush applies, and the PC is not held.
  - ex_halt together with a branch: the halt wins.

## Test plan
- **Load-use:** `ex_mem_to_reg`=1, `ex_rt_dest`=5, `id_rs`=5 in RUN. Expect `pc_hold`=`if_id_hold`=`id_ex_flush`=1 for 1 cycle and `stall_cycles`=1. Repeating with `ex_rt_dest`=0 produces no stall.
- **Branch:** `ex_branch_taken`=1 for 1 cycle. Expect `if_id_flush`=`id_ex_flush`=1 and `pc_hold`=0. Repeat with a load-use hazard active in the same cycle: the result is unchanged.
- **Cache wait:** `mem_req`=1 with `mem_ready` low for 4 cycles. Expect all holds high for 4 cycles, dropping in the `mem_ready` cycle, and `stall_cycles`=4. Repeat with `ex_branch_taken` held high throughout: the flush appears only in the `mem_ready` cycle.
- **Halt:** with DRAIN_CYCLES=3, pulse `ex_halt`. Expect 4 cycles of bubble injection, then `halted`=1 with all holds 1. A `mem_req` stall of 2 cycles inside the drain delays `halted` by exactly 2 cycles.
- **Reset mid-drain:** assert `rst` during DRAIN. The next cycle is RUN with all outputs and `stall_cycles` at 0.
- **Saturation:** preload or force `stall_cycles` to 0xFFFFFFFE, then apply 3 stall cycles. The counter reads 0xFFFFFFFF and stays there.
